// File: rtl/axis_bitop_stage.sv
// axis_bitop_stage: per-packet bitwise transform (pass / NOT / XOR key /
// XNOR key) between the host receive and send streams, with a main
// register plus one skid entry, tkeep byte zeroing and send-side counters.
module axis_bitop_stage #(
  parameter int DATA_BITS = 512,
  parameter int KEY_BITS  = 64,
  parameter int ID_BITS   = 6,
  parameter int CNT_BITS  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_BITS-1:0]   axis_host_recv_tdata,
  input  logic [DATA_BITS/8-1:0] axis_host_recv_tkeep,
  input  logic [ID_BITS-1:0]     axis_host_recv_tid,
  input  logic                   axis_host_recv_tlast,
  input  logic                   axis_host_recv_tvalid,
  output logic                   axis_host_recv_tready,
  output logic [DATA_BITS-1:0]   axis_host_send_tdata,
  output logic [DATA_BITS/8-1:0] axis_host_send_tkeep,
  output logic [ID_BITS-1:0]     axis_host_send_tid,
  output logic                   axis_host_send_tlast,
  output logic                   axis_host_send_tvalid,
  input  logic                   axis_host_send_tready,
  input  logic [1:0]             cfg_mode,
  input  logic [KEY_BITS-1:0]    cfg_key,
  input  logic                   clr_stats,
  output logic [CNT_BITS-1:0]    pkt_cnt,
  output logic [CNT_BITS-1:0]    beat_cnt
);

  localparam int KEEP_BITS = DATA_BITS / 8;
  localparam int REPS      = DATA_BITS / KEY_BITS;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic [KEEP_BITS-1:0] keep;
    logic [ID_BITS-1:0]   id;
    logic                 last;
  } beat_t;

  beat_t                main_q, main_next, skid_q, skid_next, in_beat;
  logic                 main_vld, main_vld_next, skid_vld, skid_vld_next;
  logic                 rdy_q, in_pkt;
  logic [1:0]           mode_q, mode_eff;
  logic [KEY_BITS-1:0]  key_q, key_eff;
  logic [DATA_BITS-1:0] key_rep, xf_data;
  logic                 acc, emit;

  assign acc  = axis_host_recv_tvalid & rdy_q;
  assign emit = main_vld & axis_host_send_tready;

  assign axis_host_recv_tready = rdy_q;
  assign axis_host_send_tvalid = main_vld;
  assign axis_host_send_tdata  = main_q.data;
  assign axis_host_send_tkeep  = main_q.keep;
  assign axis_host_send_tid    = main_q.id;
  assign axis_host_send_tlast  = main_q.last;

  // Transform the incoming beat; the first beat of a packet bypasses the
  // latched config so it already sees the new mode/key.
  always_comb begin
    mode_eff = in_pkt ? mode_q : cfg_mode;
    key_eff  = in_pkt ? key_q  : cfg_key;
    key_rep  = {REPS{key_eff}};
    case (mode_eff)
      2'd0:    xf_data = axis_host_recv_tdata;
      2'd1:    xf_data = ~axis_host_recv_tdata;
      2'd2:    xf_data = axis_host_recv_tdata ^ key_rep;
      default: xf_data = ~(axis_host_recv_tdata ^ key_rep);
    endcase
    for (int i = 0; i < KEEP_BITS; i++) begin
      if (!axis_host_recv_tkeep[i]) xf_data[8*i +: 8] = 8'h00;
    end
    in_beat.data = xf_data;
    in_beat.keep = axis_host_recv_tkeep;
    in_beat.id   = axis_host_recv_tid;
    in_beat.last = axis_host_recv_tlast;
  end

  // Main/skid next state: main refills from skid first, then from input;
  // input only goes to skid when main is full and not emitting.
  always_comb begin
    main_next     = main_q;
    skid_next     = skid_q;
    main_vld_next = main_vld;
    skid_vld_next = skid_vld;
    if (emit || !main_vld) begin
      if (skid_vld) begin
        main_next     = skid_q;
        main_vld_next = 1'b1;
        skid_vld_next = 1'b0;
      end else if (acc) begin
        main_next     = in_beat;
        main_vld_next = 1'b1;
      end else begin
        main_vld_next = 1'b0;
      end
    end else if (acc) begin
      skid_next     = in_beat;
      skid_vld_next = 1'b1;
    end
  end

  // Valid flags and registered ready; ready follows the skid occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      main_vld <= main_vld_next;
      skid_vld <= skid_vld_next;
      rdy_q    <= ~skid_vld_next;
    end
  end

  // Beat payload registers need no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    main_q <= main_next;
    skid_q <= skid_next;
  end

  // Packet tracking and per-packet config latch on the first accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_pkt <= 1'b0;
      mode_q <= 2'd0;
      key_q  <= '0;
    end else if (acc) begin
      in_pkt <= ~axis_host_recv_tlast;
      if (!in_pkt) begin
        mode_q <= cfg_mode;
        key_q  <= cfg_key;
      end
    end
  end

  // Send-side statistics; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt  <= '0;
      beat_cnt <= '0;
    end else if (clr_stats) begin
      pkt_cnt  <= '0;
      beat_cnt <= '0;
    end else if (emit) begin
      beat_cnt <= beat_cnt + 1'b1;
      if (main_q.last) pkt_cnt <= pkt_cnt + 1'b1;
    end
  end

endmodule
